// File: rtl/calc_core_if.sv
// calc_core_if: operand/op request and result bus between digit validation, calc_core and display.
// err_cnt is present only when CALC_ERR_CNT_EN is defined.
interface calc_core_if;
    logic [3:0] a;
    logic [3:0] b;
    logic       err_a;
    logic       err_b;
    logic [1:0] op;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       neg;
    logic [3:0] rem_out;
    logic       err;
`ifdef CALC_ERR_CNT_EN
    logic [3:0] err_cnt;
`endif
    modport master (
        output a, b, err_a, err_b, op, start,
        input  busy, done, result, neg, rem_out, err
`ifdef CALC_ERR_CNT_EN
        , input err_cnt
`endif
    );
    modport slave (
        input  a, b, err_a, err_b, op, start,
        output busy, done, result, neg, rem_out, err
`ifdef CALC_ERR_CNT_EN
        , output err_cnt
`endif
    );
endinterface

// File: rtl/calc_core.sv
// calc_core: multi-cycle BCD digit add/sub/mul/div with binary-to-BCD conversion and done pulse.
// Optional CALC_ERR_CNT_EN adds a saturating error-completion counter (err_cnt).
module calc_core #(
    parameter logic [7:0] ERR_CODE = 8'hEE
) (
    input  logic        clk,
    input  logic        rst,
    calc_core_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;
    state_t     state;
    logic [3:0] a_r, b_r, cnt, tens, rem_r, rem_out_r;
    logic [1:0] op_r;
    logic [6:0] bin;
    logic [6:0] a7, b7;
    logic       neg_r, neg_out_r, done_r, err_r;
    logic [7:0] result_r;
`ifdef CALC_ERR_CNT_EN
    logic [3:0] err_cnt_r;
    assign bus.err_cnt = err_cnt_r;
`endif
    assign a7 = {3'b0, a_r};
    assign b7 = {3'b0, b_r};
    assign bus.busy    = state != IDLE;
    assign bus.done    = done_r;
    assign bus.result  = result_r;
    assign bus.neg     = neg_out_r;
    assign bus.rem_out = rem_out_r;
    assign bus.err     = err_r;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= '0;
            cnt       <= '0;
            tens      <= '0;
            rem_r     <= '0;
            bin       <= '0;
            neg_r     <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= '0;
            neg_out_r <= 1'b0;
            rem_out_r <= '0;
            err_r     <= 1'b0;
`ifdef CALC_ERR_CNT_EN
            err_cnt_r <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_r   <= bus.a;
                    b_r   <= bus.b;
                    op_r  <= bus.op;
                    neg_r <= 1'b0;
                    tens  <= '0;
                    rem_r <= '0;
                    // Div reuses bin as the running dividend and cnt as the quotient
                    bin   <= bus.op == 2'b11 ? {3'b0, bus.a} : 7'd0;
                    cnt   <= bus.op == 2'b10 ? bus.b : 4'd0;
                    if (bus.err_a || bus.err_b || (bus.op == 2'b11 && bus.b == 4'd0)) begin
                        result_r  <= ERR_CODE;
                        err_r     <= 1'b1;
                        neg_out_r <= 1'b0;
                        rem_out_r <= '0;
                        done_r    <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: case (op_r)
                    2'b00: begin
                        bin   <= a7 + b7;
                        state <= CONV;
                    end
                    2'b01: begin
                        bin   <= a_r >= b_r ? a7 - b7 : b7 - a7;
                        neg_r <= a_r < b_r;
                        state <= CONV;
                    end
                    2'b10: if (cnt == 4'd0) state <= CONV;
                    else begin
                        bin <= bin + a7;
                        cnt <= cnt - 4'd1;
                    end
                    default: if (bin >= b7) begin
                        bin <= bin - b7;
                        cnt <= cnt + 4'd1;
                    end else begin
                        bin   <= {3'b0, cnt};
                        rem_r <= bin[3:0];
                        state <= CONV;
                    end
                endcase
                CONV: if (bin >= 7'd10) begin
                    bin  <= bin - 7'd10;
                    tens <= tens + 4'd1;
                end else begin
                    result_r  <= {tens, bin[3:0]};
                    neg_out_r <= neg_r;
                    rem_out_r <= rem_r;
                    err_r     <= 1'b0;
                    done_r    <= 1'b1;
                    state     <= DONE;
                end
                default: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
`ifdef CALC_ERR_CNT_EN
                    err_cnt_r <= err_r && err_cnt_r != 4'd15 ? err_cnt_r + 4'd1 : err_cnt_r;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: directed vector table for calc_core plus restart-ignore and mid-operation reset sequences.
// Also checks err_cnt when CALC_ERR_CNT_EN is defined.
module tb_calc_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    calc_core_if bus ();
    calc_core #(.ERR_CODE(8'hEE)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       ea;
        logic       eb;
        logic [7:0] res;
        logic       neg;
        logic [3:0] rem;
        logic       err;
        int         lat;
    } vec_t;
    vec_t v[14];
    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic launch(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic ea, input logic eb);
        @(negedge clk);
        bus.op = op; bus.a = a; bus.b = b; bus.err_a = ea; bus.err_b = eb; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 0; n < 100; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask
    int lat, saw;
`ifdef CALC_ERR_CNT_EN
    int exp_cnt = 0;
`endif
    initial begin
        v[0]  = '{2'b00, 4'd7, 4'd8, 1'b0, 1'b0, 8'h15, 1'b0, 4'd0, 1'b0, 3};
        v[1]  = '{2'b01, 4'd3, 4'd7, 1'b0, 1'b0, 8'h04, 1'b1, 4'd0, 1'b0, 2};
        v[2]  = '{2'b10, 4'd9, 4'd9, 1'b0, 1'b0, 8'h81, 1'b0, 4'd0, 1'b0, 19};
        v[3]  = '{2'b10, 4'd5, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 2};
        v[4]  = '{2'b11, 4'd9, 4'd2, 1'b0, 1'b0, 8'h04, 1'b0, 4'd1, 1'b0, 6};
        v[5]  = '{2'b11, 4'd5, 4'd0, 1'b0, 1'b0, 8'hEE, 1'b0, 4'd0, 1'b1, 0};
        v[6]  = '{2'b00, 4'd2, 4'd3, 1'b1, 1'b0, 8'hEE, 1'b0, 4'd0, 1'b1, 0};
        v[7]  = '{2'b01, 4'd9, 4'd9, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 2};
        v[8]  = '{2'b01, 4'd8, 4'd1, 1'b0, 1'b0, 8'h07, 1'b0, 4'd0, 1'b0, 2};
        v[9]  = '{2'b00, 4'd9, 4'd9, 1'b0, 1'b0, 8'h18, 1'b0, 4'd0, 1'b0, 3};
        v[10] = '{2'b11, 4'd7, 4'd9, 1'b0, 1'b0, 8'h00, 1'b0, 4'd7, 1'b0, 2};
        v[11] = '{2'b10, 4'd3, 4'd4, 1'b0, 1'b0, 8'h12, 1'b0, 4'd0, 1'b0, 7};
        v[12] = '{2'b11, 4'd8, 4'd4, 1'b0, 1'b0, 8'h02, 1'b0, 4'd0, 1'b0, 4};
        v[13] = '{2'b01, 4'd4, 4'd2, 1'b0, 1'b1, 8'hEE, 1'b0, 4'd0, 1'b1, 0};
        bus.a = '0; bus.b = '0; bus.op = '0; bus.err_a = 1'b0; bus.err_b = 1'b0; bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset result", bus.result, 0);
        chk("reset neg", bus.neg, 0);
        chk("reset rem_out", bus.rem_out, 0);
        chk("reset err", bus.err, 0);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            launch(v[i].op, v[i].a, v[i].b, v[i].ea, v[i].eb);
            wait_done(lat);
            chk($sformatf("v%0d latency", i), lat, v[i].lat);
            chk($sformatf("v%0d result", i), bus.result, v[i].res);
            chk($sformatf("v%0d neg", i), bus.neg, v[i].neg);
            chk($sformatf("v%0d rem_out", i), bus.rem_out, v[i].rem);
            chk($sformatf("v%0d err", i), bus.err, v[i].err);
            chk($sformatf("v%0d busy in done", i), bus.busy, 1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d done pulse end", i), bus.done, 0);
            chk($sformatf("v%0d idle after", i), bus.busy, 0);
            chk($sformatf("v%0d result held", i), bus.result, v[i].res);
`ifdef CALC_ERR_CNT_EN
            if (v[i].err && exp_cnt < 15) exp_cnt++;
            chk($sformatf("v%0d err_cnt", i), bus.err_cnt, exp_cnt);
`endif
        end
        // Re-pulsing start with new operands mid-mul must not disturb 9*9
        launch(2'b10, 4'd9, 4'd9, 1'b0, 1'b0);
        lat = -1;
        for (int n = 1; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (n == 3) begin
                bus.a = 4'd1; bus.b = 4'd1; bus.op = 2'b00; bus.start = 1'b1;
            end
            if (n == 4) bus.start = 1'b0;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        chk("restart latency", lat, 19);
        chk("restart result", bus.result, 8'h81);
        @(posedge clk);
        #1;
        chk("restart idle after", bus.busy, 0);
        // Reset asserted just after edge 8 of a mul aborts without done
        launch(2'b10, 4'd9, 4'd9, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort busy", bus.busy, 0);
        chk("abort done", bus.done, 0);
        chk("abort result", bus.result, 0);
        chk("abort neg", bus.neg, 0);
        chk("abort rem_out", bus.rem_out, 0);
        chk("abort err", bus.err, 0);
`ifdef CALC_ERR_CNT_EN
        chk("abort err_cnt", bus.err_cnt, 0);
`endif
        @(negedge clk) rst = 1'b1;
        saw = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) saw = 1;
        end
        chk("no done after abort", saw, 0);
        launch(2'b00, 4'd2, 4'd3, 1'b0, 1'b0);
        wait_done(lat);
        chk("post-reset latency", lat, 2);
        chk("post-reset result", bus.result, 8'h05);
        chk("post-reset err", bus.err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/calc_core.md
Name: calc_core

Overview:
- Arithmetic stage directly downstream of the BCD digit validation stage.
- Consumes the two validated single BCD digits (a, b) and their error flags.
- Performs add, subtract, multiply or divide as a multi-cycle FSM. Multiply is repeated addition; divide is repeated subtraction.
- Converts the binary result to two BCD digits and reports completion with a one-cycle done pulse for the display stage.

Parameters:
- ERR_CODE, 8'hEE, value driven on result when an error completion occurs.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- a  input  4  operand A, BCD digit 0-9.
- b  input  4  operand B, BCD digit 0-9.
- err_a  input  1  operand A invalid.
- err_b  input  1  operand B invalid.
- op  input  2  operation select: 00 add, 01 sub, 10 mul, 11 div.
- start  input  1  request; sampled only in IDLE.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- result  output  8  {tens, ones} BCD.
- neg  output  1  subtraction result negative.
- rem_out  output  4  division remainder, binary 0-8.
- err  output  1  error flag for the last operation.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - busy, done, result, neg, rem_out and err all go to 0.
  - All internal accumulators and counters are cleared.
  - Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, CALC, CONV, DONE. Edge 0 is the edge that samples start=1 in IDLE.
- IDLE:
  - On start, capture a, b and op.
  - If err_a or err_b is set, or op=11 with b=0, go directly to DONE with the error flagged.
  - Otherwise go to CALC.
  - start is ignored in CALC, CONV and DONE. Input changes after capture are ignored.
- CALC:
  - add: bin = a + b; one cycle, then CONV.
  - sub: if a >= b, bin = a - b and neg = 0. Otherwise bin = b - a and neg = 1. One cycle, then CONV.
  - mul: counter is loaded with b and acc = 0. Each cycle: if counter = 0, go to CONV; else acc += a and counter decrements. Takes b+1 cycles; b = 0 gives 0.
  - div: acc = a and q = 0. Each cycle: if acc >= b, acc -= b and q++; else go to CONV with bin = q and remainder = acc. Takes q+1 cycles.
  - Internal width is 7 bits; the maximum value is 81.
- CONV: each cycle, if bin >= 10 then bin -= 10 and tens++; else go to DONE. Takes tens+1 cycles.
- DONE: lasts one cycle, with done = 1. Outputs are registered on entry to DONE, then the FSM returns to IDLE.
- Latency: done is high in the cycle after edge (C_calc + C_conv). On an error path, done is high after edge 0.
- Output values:
  - result, neg, rem_out and err hold until the next completion.
  - neg = 0 for non-sub operations.
  - rem_out = 0 for non-div operations.
- Error completion: result = ERR_CODE, err = 1, neg = 0, rem_out = 0.
- A good completion clears err.

Optional Feature:
- Macro: CALC_ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt, 4 bits.
  - Counts error completions, saturating at 15.
  - Increments in the DONE cycle.
  - Cleared only by reset.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- add, a=7, b=8, start pulse -> done after edge 3; result=8'h15, neg=0, err=0.
- sub, a=3, b=7 -> done after edge 2; result=8'h04, neg=1.
- mul, a=9, b=9 -> done after edge 19; result=8'h81. With a=5, b=0: result=8'h00.
- div, a=9, b=2 -> done after edge 6; result=8'h04, rem_out=1.
- div with b=0, and separately add with err_a=1 -> done after edge 0; result=ERR_CODE, err=1.
  - With CALC_ERR_CNT_EN defined, err_cnt=2 after both.
- Mid-operation checks during mul 9*9:
  - Pulse start again -> ignored.
  - Drop rst at edge 8 -> all outputs 0 and no done pulse.
  - After release, a new start is accepted.
